srt4_otf_converter: RTL

//   On-the-fly quotient converter for the radix-4 SRT divider.

---
 rtl/srt4_otf_converter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/srt4_otf_converter.sv
// -----------------------------------------------------------------------------
// srt4_otf_converter
//   On-the-fly quotient converter for a radix-4 SRT divider. It accepts one
//   signed quotient digit in {-2..2} per handshake. It keeps two registers,
//   Q and QM = Q-1, so the two's-complement quotient is built without a
//   carry-propagate adder. When the last digit arrives, the sign of the final
//   remainder picks Q or QM as the result.
//
//   Optional feature macro: SRT4_OTF_ERRCHK_EN
//     defined   : codes 3'b011 and 3'b100 are flagged on the sticky err output
//                 and are converted as digit 0.
//     undefined : err is constant 0 and illegal codes must not be driven.
// -----------------------------------------------------------------------------
module srt4_otf_converter #(
    parameter int NDIGITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               q_valid,
    output logic               q_ready,
    input  logic [2:0]         q_digit,
    input  logic               rem_neg,
    output logic               quo_valid,
    input  logic               quo_ready,
    output logic [2*NDIGITS:0] quo,
    output logic               err
);

    localparam int QW = 2 * NDIGITS + 1;
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

`ifdef SRT4_OTF_ERRCHK_EN
    // Codes outside the digit set {-2..2}.
    function automatic logic is_illegal(input logic [2:0] d);
        return (d == 3'b011) || (d == 3'b100);
    endfunction

    // An illegal code is converted as the digit 0.
    function automatic logic [2:0] eff_digit(input logic [2:0] d);
        return is_illegal(d) ? 3'b000 : d;
    endfunction
`else
    // Without checking, the raw code is converted as it is.
    function automatic logic [2:0] eff_digit(input logic [2:0] d);
        return d;
    endfunction
`endif

    state_e          state_q, state_d;
    logic [QW-1:0]   q_q, q_d;
    logic [QW-1:0]   qm_q, qm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic            err_q, err_d;
    logic            q_ready_q, q_ready_d;
    logic            quo_valid_q, quo_valid_d;

    logic [2:0]      digit_s;
    logic            accept_s;
    logic            last_s;
    logic            illegal_s;
    logic            qm_from_q_s;
    logic [1:0]      app_q_s;
    logic [1:0]      app_qm_s;
    logic [QW-1:0]   q_nxt_s;
    logic [QW-1:0]   qm_nxt_s;

    // Digit decode and the next Q/QM values for an accepted digit.
    always_comb begin
        digit_s     = eff_digit(q_digit);
`ifdef SRT4_OTF_ERRCHK_EN
        illegal_s   = is_illegal(q_digit);
`else
        illegal_s   = 1'b0;
`endif
        accept_s    = q_valid && q_ready_q;
        last_s      = (cnt_q == CW'(NDIGITS - 1));
        // For a digit q, 4+q and q give the same two low bits, and so do
        // 3+q and q-1, whatever the sign. Only the source register depends on
        // the sign.
        app_q_s     = digit_s[1:0];
        app_qm_s    = digit_s[1:0] - 2'd1;
        qm_from_q_s = !digit_s[2] && (digit_s[1:0] != 2'b00);
        if (digit_s[2]) begin
            q_nxt_s = {qm_q[QW-3:0], app_q_s};
        end else begin
            q_nxt_s = {q_q[QW-3:0], app_q_s};
        end
        if (qm_from_q_s) begin
            qm_nxt_s = {q_q[QW-3:0], app_qm_s};
        end else begin
            qm_nxt_s = {qm_q[QW-3:0], app_qm_s};
        end
    end

    // Next-state and datapath update; start overrides everything else.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        err_d   = err_q;
        if (start) begin
            state_d = ST_CONV;
            q_d     = {QW{1'b0}};
            qm_d    = {QW{1'b1}};
            cnt_d   = {CW{1'b0}};
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CONV: begin
                    if (accept_s) begin
                        q_d   = q_nxt_s;
                        qm_d  = qm_nxt_s;
                        err_d = err_q | illegal_s;
                        if (last_s) begin
                            state_d = ST_DONE;
                            cnt_d   = {CW{1'b0}};
                            // A negative final remainder means the true
                            // quotient is one less: take QM.
                            quo_d   = rem_neg ? qm_nxt_s : q_nxt_s;
                        end else begin
                            state_d = ST_CONV;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = ST_CONV;
                    end
                end
                ST_DONE: begin
                    if (quo_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        q_ready_d   = (state_d == ST_CONV);
        quo_valid_d = (state_d == ST_DONE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            q_q         <= {QW{1'b0}};
            qm_q        <= {QW{1'b1}};
            cnt_q       <= {CW{1'b0}};
            quo_q       <= {QW{1'b0}};
            err_q       <= 1'b0;
            q_ready_q   <= 1'b0;
            quo_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            qm_q        <= qm_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            err_q       <= err_d;
            q_ready_q   <= q_ready_d;
            quo_valid_q <= quo_valid_d;
        end
    end

    assign q_ready   = q_ready_q;
    assign quo_valid = quo_valid_q;
    assign quo       = quo_q;
    assign err       = err_q;

endmodule
